spmv_row_len_gen: RTL
=====================

SPMV_ROW_LEN_GEN -- requirements
Module: spmv_row_len_gen

Interface
REQ-001 The block SHALL have parameter PTR_W, default 32, giving the width of row pointers and row lengths.
REQ-002 The block SHALL have port clk, input, 1, the single clock; all logic SHALL be on its rising edge.
REQ-003 The block SHALL have port rst, input, 1, reset: asynchronous, active-high.
REQ-004 The block SHALL have port start, input, 1, a one-cycle job-start pulse.
REQ-005 The block SHALL have port num_rows, input, PTR_W, the row count, sampled on an accepted start.
REQ-006 The block SHALL have port busy, output, 1, high from an accepted start until done.
REQ-007 The block SHALL have port done, output, 1, a one-cycle job-complete pulse.
REQ-008 The block SHALL have port err_nonmono, output, 1, a sticky flag for a non-monotonic pointer.
REQ-009 The block SHALL have port zero_rows, output, PTR_W, the count of zero-length rows in the current or last job.
REQ-010 The block SHALL have ports S_AXIS_PTR_tdata (input, PTR_W), S_AXIS_PTR_tvalid (input, 1) and S_AXIS_PTR_tready (output, 1), forming the CSR row-pointer stream.
REQ-011 The block SHALL have ports M_AXIS_TIMES_tdata (output, PTR_W), M_AXIS_TIMES_tvalid (output, 1) and M_AXIS_TIMES_tready (input, 1), forming the per-row nonzero-count stream that feeds the dot-product stage TIMES input.

Function
REQ-012 The block SHALL implement states IDLE, BASE, RUN and DONE.
REQ-013 In IDLE, start=1 with num_rows>0 SHALL go to BASE, latch num_rows, set busy=1, clear zero_rows and clear err_nonmono.
REQ-014 In IDLE, start=1 with num_rows=0 SHALL go to DONE without consuming any pointer.
REQ-015 In any state other than IDLE, start SHALL be ignored.
REQ-016 In BASE, S_AXIS_PTR_tready SHALL be 1; the first accepted pointer SHALL be stored as prev, SHALL produce no output, and the block SHALL go to RUN.
REQ-017 In RUN, S_AXIS_PTR_tready SHALL equal (!M_AXIS_TIMES_tvalid | M_AXIS_TIMES_tready) while the count of accepted rows is below num_rows, and SHALL be 0 otherwise.
REQ-018 On each pointer accepted in RUN, the block SHALL register TIMES_tdata = ptr - prev, set TIMES_tvalid=1 on the next cycle (latency 1), and set prev = ptr.
REQ-019 Throughput SHALL be one row per cycle when TIMES_tready is held at 1.
REQ-020 TIMES_tvalid SHALL stay asserted with tdata stable until a TIMES handshake occurs.
REQ-021 A simultaneous TIMES handshake and pointer acceptance in the same cycle SHALL load the new length without a bubble.
REQ-022 If ptr < prev, TIMES_tdata SHALL be 0, err_nonmono SHALL set, and prev SHALL still update to ptr.
REQ-023 Each emitted length equal to 0 SHALL increment zero_rows by 1, saturating at all-ones.
REQ-024 Row-pointer subtraction SHALL be unsigned PTR_W modulo arithmetic; no wider result SHALL be kept.
REQ-025 Exactly num_rows+1 pointers SHALL be consumed per job.
REQ-026 RUN SHALL go to DONE in the cycle the num_rows-th TIMES handshake completes.
REQ-027 DONE SHALL assert done=1 for exactly one cycle, drop busy in that same cycle, and return to IDLE.
REQ-028 In IDLE and DONE, S_AXIS_PTR_tready SHALL be 0.
REQ-029 zero_rows and err_nonmono SHALL hold their values after done until the next accepted start.

Reset
REQ-030 While rst=1, the state SHALL be IDLE and busy, done, S_AXIS_PTR_tready, M_AXIS_TIMES_tvalid, err_nonmono and zero_rows SHALL all be 0, with TIMES_tdata=0.
REQ-031 rst asserted mid-job SHALL abort the job immediately: any pending TIMES beat SHALL be dropped and no done pulse SHALL be issued.
REQ-032 After rst deasserts, the block SHALL accept a new start in the first clock edge.

Verification
REQ-033 The bench SHALL cover: num_rows=3, ptrs 0,4,4,9, tready=1 -> TIMES 4,0,5 on consecutive cycles, zero_rows=1, done one cycle after the last beat, exactly 4 ptrs consumed.
REQ-034 The bench SHALL cover: num_rows=0 start -> done pulse, busy high for 1 cycle, PTR_tready never 1, no TIMES beat.
REQ-035 The bench SHALL cover: num_rows=2, ptrs 10,7,12 -> TIMES 0,5, err_nonmono=1, zero_rows=1.
REQ-036 The bench SHALL cover: num_rows=4, ptrs 0,1,2,3,4, TIMES_tready toggling 1/0 -> TIMES 1,1,1,1 with no loss or duplication and tdata stable while stalled.
REQ-037 The bench SHALL cover: rst pulse after 2 of 5 rows emitted -> all outputs 0 next cycle, no done; a new job with num_rows=1 and ptrs 0,8 -> TIMES 8 and done.
REQ-038 The bench SHALL cover: start pulsed while busy -> ignored, with the job result unchanged.

Source files
------------

// File: rtl/spmv_row_len_gen.sv
// spmv_row_len_gen: turns a CSR row-pointer stream into per-row nonzero counts
//   clk/rst            : rising-edge clock, async active-high reset
//   start/num_rows     : job start pulse and row count (sampled on an accepted start)
//   busy/done          : busy covers the whole job up to and including the done cycle
//   err_nonmono        : sticky, a pointer went backwards during the job
//   zero_rows          : zero-length rows emitted in the current or last job (saturating)
//   S_AXIS_PTR_*       : row pointers in, num_rows+1 per job
//   M_AXIS_TIMES_*     : row lengths out, one per row
module spmv_row_len_gen #(
  parameter int PTR_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [PTR_W-1:0] num_rows,
  output logic             busy,
  output logic             done,
  output logic             err_nonmono,
  output logic [PTR_W-1:0] zero_rows,
  input  logic [PTR_W-1:0] S_AXIS_PTR_tdata,
  input  logic             S_AXIS_PTR_tvalid,
  output logic             S_AXIS_PTR_tready,
  output logic [PTR_W-1:0] M_AXIS_TIMES_tdata,
  output logic             M_AXIS_TIMES_tvalid,
  input  logic             M_AXIS_TIMES_tready
);
  typedef enum logic [1:0] {IDLE, BASE, RUN, DONE} state_t;
  state_t r_state, w_next;
  logic [PTR_W-1:0] r_rows, r_cnt, r_prev, r_tdata, r_zero;
  logic r_tvalid, r_err;
  logic w_acc, w_hs, w_lt;
  logic [PTR_W-1:0] w_len;
  assign w_acc = S_AXIS_PTR_tvalid & S_AXIS_PTR_tready;
  assign w_hs = r_tvalid & M_AXIS_TIMES_tready;
  assign w_lt = S_AXIS_PTR_tdata < r_prev;
  // a backwards pointer yields a zero length rather than a wrapped difference
  assign w_len = w_lt ? '0 : S_AXIS_PTR_tdata - r_prev;
  assign M_AXIS_TIMES_tdata = r_tdata;
  assign M_AXIS_TIMES_tvalid = r_tvalid;
  assign err_nonmono = r_err;
  assign zero_rows = r_zero;
  always_ff @(posedge clk or posedge rst)
    if (rst) r_state <= IDLE;
    else r_state <= w_next;
  always_comb begin
    w_next = r_state;
    S_AXIS_PTR_tready = 1'b0;
    busy = r_state != IDLE;
    done = r_state == DONE;
    case (r_state)
      IDLE: if (start) w_next = (num_rows == '0) ? DONE : BASE;
      BASE: begin
        S_AXIS_PTR_tready = 1'b1;
        if (S_AXIS_PTR_tvalid) w_next = RUN;
      end
      RUN: begin
        S_AXIS_PTR_tready = (r_cnt != r_rows) & (~r_tvalid | M_AXIS_TIMES_tready);
        // output register holds one beat, so a handshake once all rows are loaded is the last one
        if (w_hs && r_cnt == r_rows) w_next = DONE;
      end
      default: w_next = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      r_rows <= '0;
      r_cnt <= '0;
      r_prev <= '0;
      r_tdata <= '0;
      r_tvalid <= 1'b0;
      r_zero <= '0;
      r_err <= 1'b0;
    end else begin
      // job statistics restart on any accepted start, including an empty job
      if (r_state == IDLE && start) begin
        r_rows <= num_rows;
        r_zero <= '0;
        r_err <= 1'b0;
      end
      if (r_state == BASE && w_acc) begin
        r_prev <= S_AXIS_PTR_tdata;
        r_cnt <= '0;
      end
      if (r_state == RUN && w_acc) begin
        r_prev <= S_AXIS_PTR_tdata;
        r_cnt <= r_cnt + 1'b1;
        r_tdata <= w_len;
        r_tvalid <= 1'b1;
        if (w_len == '0 && ~&r_zero) r_zero <= r_zero + 1'b1;
        if (w_lt) r_err <= 1'b1;
      end else if (w_hs) r_tvalid <= 1'b0;
    end
endmodule
